overflow_counter: RTL and testbench

Parametrised up/down accumulator with overflow and underflow detection. It is the registered successor to the combinational 8-bit overflow indicator. Each enabled cycle it adds or subtracts a programmable step. It selects wrap-around or saturating arithmetic at run time, and reports per-cycle pulses, sticky flags and a saturating event count. It sits on the datapath side of the bus interface for address/burst counting and buffer-level tracking.

---
 rtl/overflow_counter.sv | 114 +++++++++++
 tb/tb_overflow_counter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/overflow_counter.sv
// Registered up/down accumulator with wrap or saturating arithmetic,
// overflow/underflow pulses, sticky flags and a saturating event count.
//
// Ports:
//   clk, reset       - clock and synchronous active-high reset
//   en, up, step     - advance by step this cycle, up=1 adds, up=0 subtracts
//   satMode          - 1 clamps at the bounds, 0 wraps modulo 2^WIDTH
//   load, loadValue  - load a new count (takes priority over en)
//   clearFlags       - clear sticky flags and the event count
//   count            - registered counter value
//   overflowPulse    - high one cycle after an upward crossing of the max
//   underflowPulse   - high one cycle after a downward crossing of zero
//   overflowSticky   - held high after any overflow until cleared
//   underflowSticky  - held high after any underflow until cleared
//   eventCount       - overflow+underflow events, saturating at all-ones
module overflow_counter #(
    parameter int WIDTH     = 8,
    parameter int STEP_W    = 4,
    parameter int EVT_W     = 4,
    parameter int RESET_VAL = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              up,
    input  logic [STEP_W-1:0] step,
    input  logic              satMode,
    input  logic              load,
    input  logic [WIDTH-1:0]  loadValue,
    input  logic              clearFlags,
    output logic [WIDTH-1:0]  count,
    output logic              overflowPulse,
    output logic              underflowPulse,
    output logic              overflowSticky,
    output logic              underflowSticky,
    output logic [EVT_W-1:0]  eventCount
);

    localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VAL);

    logic [WIDTH:0]      step_ext;
    logic [WIDTH:0]      sum;
    logic [WIDTH:0]      diff;
    logic                advance;
    logic                ovf;
    logic                unf;
    logic                evt;
    logic [WIDTH-1:0]    count_nxt;
    logic                ovf_sticky_nxt;
    logic                unf_sticky_nxt;
    logic [EVT_W-1:0]    evt_cnt_nxt;

    always_comb begin
        step_ext       = (WIDTH+1)'(step);
        sum            = {1'b0, count} + step_ext;
        diff           = {1'b0, count} - step_ext;
        // load wins over en, so a step is only applied without load
        advance        = en & ~load;
        // carry/borrow out of the extended result marks the crossing;
        // a clamped counter re-crosses on every further attempt
        ovf            = advance & up & sum[WIDTH];
        unf            = advance & ~up & diff[WIDTH];
        evt            = ovf | unf;

        count_nxt      = count;
        if (load) begin
            count_nxt = loadValue;
        end else if (en) begin
            if (up) begin
                if (ovf && satMode) begin
                    count_nxt = '1;
                end else begin
                    count_nxt = sum[WIDTH-1:0];
                end
            end else begin
                if (unf && satMode) begin
                    count_nxt = '0;
                end else begin
                    count_nxt = diff[WIDTH-1:0];
                end
            end
        end

        // a new event on the clearing edge survives the clear
        ovf_sticky_nxt = ovf | (overflowSticky & ~clearFlags);
        unf_sticky_nxt = unf | (underflowSticky & ~clearFlags);

        evt_cnt_nxt    = eventCount;
        if (clearFlags) begin
            evt_cnt_nxt = EVT_W'(evt);
        end else if (evt && !(&eventCount)) begin
            evt_cnt_nxt = eventCount + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count           <= RST_COUNT;
            overflowPulse   <= 1'b0;
            underflowPulse  <= 1'b0;
            overflowSticky  <= 1'b0;
            underflowSticky <= 1'b0;
            eventCount      <= '0;
        end else begin
            count           <= count_nxt;
            overflowPulse   <= ovf;
            underflowPulse  <= unf;
            overflowSticky  <= ovf_sticky_nxt;
            underflowSticky <= unf_sticky_nxt;
            eventCount      <= evt_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_overflow_counter.sv
// Directed bench for overflow_counter with default parameters
// (WIDTH=8, STEP_W=4, EVT_W=4, RESET_VAL=0).
module tb_overflow_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up;
    logic [3:0] step;
    logic       satMode;
    logic       load;
    logic [7:0] loadValue;
    logic       clearFlags;
    logic [7:0] count;
    logic       overflowPulse;
    logic       underflowPulse;
    logic       overflowSticky;
    logic       underflowSticky;
    logic [3:0] eventCount;

    int tests;
    int fails;

    overflow_counter dut (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .up             (up),
        .step           (step),
        .satMode        (satMode),
        .load           (load),
        .loadValue      (loadValue),
        .clearFlags     (clearFlags),
        .count          (count),
        .overflowPulse  (overflowPulse),
        .underflowPulse (underflowPulse),
        .overflowSticky (overflowSticky),
        .underflowSticky(underflowSticky),
        .eventCount     (eventCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] c,
                           input logic op, input logic upl,
                           input logic os, input logic us,
                           input logic [3:0] ev);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".ovfPulse"}, 32'(overflowPulse), 32'(op));
        chk({tag, ".unfPulse"}, 32'(underflowPulse), 32'(upl));
        chk({tag, ".ovfSticky"}, 32'(overflowSticky), 32'(os));
        chk({tag, ".unfSticky"}, 32'(underflowSticky), 32'(us));
        chk({tag, ".evtCount"}, 32'(eventCount), 32'(ev));
    endtask

    task automatic idle();
        en = 0; load = 0; clearFlags = 0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1; en = 0; up = 1; step = 0; satMode = 0;
        load = 0; loadValue = 0; clearFlags = 0;
        tick();
        tick();
        chk_all("reset", 8'd0, 0, 0, 0, 0, 4'd0);

        // full wrap: 256 single steps
        reset = 0; en = 1; up = 1; step = 1; satMode = 0;
        for (int i = 1; i <= 256; i++) begin
            tick();
            chk("wrap.count", 32'(count), 32'(i % 256));
            chk("wrap.ovfPulse", 32'(overflowPulse), 32'(i == 256));
        end
        idle();
        tick();
        chk_all("wrap.after", 8'd0, 0, 0, 1, 0, 4'd1);

        // saturating up: load 250 with a clear, then three steps of 10
        load = 1; loadValue = 250; clearFlags = 1;
        tick();
        chk_all("sat.load", 8'd250, 0, 0, 0, 0, 4'd0);
        idle(); en = 1; up = 1; step = 10; satMode = 1;
        tick();
        chk_all("sat.up1", 8'd255, 1, 0, 1, 0, 4'd1);
        tick();
        chk_all("sat.up2", 8'd255, 1, 0, 1, 0, 4'd2);
        tick();
        chk_all("sat.up3", 8'd255, 1, 0, 1, 0, 4'd3);

        // knobs change while en=0: no effect
        idle(); up = 0; step = 15; satMode = 0;
        tick();
        chk_all("hold", 8'd255, 0, 0, 1, 0, 4'd3);

        // down underflow, wrap then saturating
        load = 1; loadValue = 3;
        tick();
        idle(); en = 1; up = 0; step = 5; satMode = 0;
        tick();
        chk_all("dn.wrap", 8'd254, 0, 1, 1, 1, 4'd4);
        idle(); load = 1; loadValue = 3;
        tick();
        idle(); en = 1; up = 0; step = 5; satMode = 1;
        tick();
        chk_all("dn.sat", 8'd0, 0, 1, 1, 1, 4'd5);
        tick();
        chk_all("dn.sat2", 8'd0, 0, 1, 1, 1, 4'd6);

        // clear on a non-event cycle
        idle(); clearFlags = 1;
        tick();
        chk_all("clear", 8'd0, 0, 0, 0, 0, 4'd0);

        // 20 wrap overflows: eventCount saturates at 15
        satMode = 0; up = 1; step = 15;
        for (int k = 1; k <= 20; k++) begin
            idle(); load = 1; loadValue = 250;
            tick();
            idle(); en = 1;
            tick();
            chk("evt.count", 32'(count), 32'd9);
            chk("evt.ovfPulse", 32'(overflowPulse), 32'd1);
            chk("evt.sat", 32'(eventCount), 32'(k > 15 ? 15 : k));
        end

        // underflow, then an overflow coincident with clearFlags
        idle(); load = 1; loadValue = 0;
        tick();
        idle(); en = 1; up = 0; step = 1; satMode = 0;
        tick();
        chk_all("pre.clr", 8'd255, 0, 1, 1, 1, 4'd15);
        idle(); en = 1; up = 1; step = 1; clearFlags = 1;
        tick();
        chk_all("clr.evt", 8'd0, 1, 0, 1, 0, 4'd1);

        // load beats en
        idle(); load = 1; en = 1; loadValue = 100; step = 7; up = 1;
        tick();
        chk_all("ld.en", 8'd100, 0, 0, 1, 0, 4'd1);

        // step 0 is not an event in either direction
        idle(); en = 1; step = 0; up = 1;
        tick();
        chk_all("step0.up", 8'd100, 0, 0, 1, 0, 4'd1);
        up = 0;
        tick();
        chk_all("step0.dn", 8'd100, 0, 0, 1, 0, 4'd1);

        // mid-operation reset with stickies set and load asserted
        idle(); load = 1; loadValue = 0;
        tick();
        idle(); en = 1; up = 0; step = 1;
        tick();
        idle(); load = 1; loadValue = 77;
        tick();
        chk_all("pre.rst", 8'd77, 0, 0, 1, 1, 4'd2);
        reset = 1; load = 1; loadValue = 5; en = 1; up = 1;
        step = 3; clearFlags = 0;
        tick();
        chk_all("mid.rst", 8'd0, 0, 0, 0, 0, 4'd0);
        reset = 0; idle();
        tick();
        chk_all("post.rst", 8'd0, 0, 0, 0, 0, 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
